// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I execute-stage ALU.
//   XLEN         : datapath width (32)
//   funct3_e     : R-type funct3 operation encodings
//   shift_mode_e : barrel shifter direction/fill selection
//   bit_reverse  : helper used to reuse the right shifter for left shifts
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ADD_SUB = 3'b000,
        SLL     = 3'b001,
        SLT     = 3'b010,
        SLTU    = 3'b011,
        XOR     = 3'b100,
        SRL_SRA = 3'b101,
        OR      = 3'b110,
        AND     = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        SHIFT_LL = 2'b00,   // logical left
        SHIFT_RL = 2'b01,   // logical right
        SHIFT_RA = 2'b10    // arithmetic right
    } shift_mode_e;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational 32-bit barrel shifter, five log2 stages.
//   data  in  [XLEN-1:0] value to shift
//   shamt in  [4:0]      shift amount
//   mode  in  shift_mode_e  left / logical right / arithmetic right
//   res   out [XLEN-1:0] shifted value
// Left shifts are done by reversing the operand, shifting right with zero
// fill, and reversing back, so only one right-shift network is built.
// -----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  shift_mode_e     mode,
    output logic [XLEN-1:0] res
);

    logic            fill;
    logic [XLEN-1:0] stage [0:5];

    // Sign fill only for arithmetic right; left and logical right fill zeros.
    assign fill     = (mode == SHIFT_RA) ? data[XLEN-1] : 1'b0;
    assign stage[0] = (mode == SHIFT_LL) ? bit_reverse(data) : data;

    for (genvar g = 0; g < 5; g++) begin : g_stage
        localparam int SH = 1 << g;
        assign stage[g+1] = shamt[g] ? {{SH{fill}}, stage[g][XLEN-1:SH]}
                                     : stage[g];
    end

    assign res = (mode == SHIFT_LL) ? bit_reverse(stage[5]) : stage[5];

endmodule

// File: rtl/rv32_alu.sv
// -----------------------------------------------------------------------------
// rv32_alu
// Registered RV32I R-type ALU with zero flag, one cycle latency, one op/cycle.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (rd=0, z=0 while low)
//   rs1    in  [31:0] operand A
//   rs2    in  [31:0] operand B (shift amount = rs2[4:0])
//   funct3 in  [2:0]  operation select
//   funct7 in  instruction bit 30: SUB over ADD, SRA over SRL
//   rd     out [31:0] registered result
//   z      out registered flag, 1 when the loaded result is zero
// -----------------------------------------------------------------------------
module rv32_alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic [XLEN-1:0] rd,
    output logic            z
);

    funct3_e         op;
    logic            sub;
    logic [XLEN-1:0] b_op;
    logic [XLEN-1:0] sum;
    logic            lt_s;
    logic            lt_u;
    shift_mode_e     sh_mode;
    logic [XLEN-1:0] sh_res;
    logic [XLEN-1:0] result;
    logic            result_zero;

    assign op = funct3_e'(funct3);

    // One adder serves ADD and SUB: rs1 - rs2 == rs1 + ~rs2 + 1.
    assign sub  = (op == ADD_SUB) && funct7;
    assign b_op = sub ? ~rs2 : rs2;
    assign sum  = rs1 + b_op + XLEN'(sub);

    assign lt_s = $signed(rs1) < $signed(rs2);
    assign lt_u = rs1 < rs2;

    // funct7 only matters for SRL/SRA; SLL always shifts left.
    assign sh_mode = (op == SLL) ? SHIFT_LL :
                     funct7      ? SHIFT_RA : SHIFT_RL;

    alu_shifter u_shifter (
        .data  (rs1),
        .shamt (rs2[4:0]),
        .mode  (sh_mode),
        .res   (sh_res)
    );

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch can be inferred even if an arm is later removed.
        result = '0;
        unique case (op)
            ADD_SUB: result = sum;
            SLL:     result = sh_res;
            SLT:     result = {{(XLEN-1){1'b0}}, lt_s};
            SLTU:    result = {{(XLEN-1){1'b0}}, lt_u};
            XOR:     result = rs1 ^ rs2;
            SRL_SRA: result = sh_res;
            OR:      result = rs1 | rs2;
            AND:     result = rs1 & rs2;
            default: result = '0;
        endcase
    end

    // Flag taken from the same combinational value that loads rd.
    assign result_zero = (result == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset forces both outputs low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
            z  <= 1'b0;
        end else begin
            rd <= result;
            z  <= result_zero;
        end
    end

endmodule

// File: tb/tb_rv32_alu.sv
// -----------------------------------------------------------------------------
// tb_rv32_alu
// Scoreboard bench for rv32_alu. The driver applies one operation per falling
// edge and queues the hand-computed result; the monitor pops one entry after
// each rising edge and compares rd and z.
// -----------------------------------------------------------------------------
module tb_rv32_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] rd;
    logic        z;

    typedef struct {
        logic [31:0] rd;
        logic        z;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    rv32_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .z      (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        funct3 = f3;
        funct7 = f7;
        rs1    = a;
        rs2    = b;
        e.rd   = exp;
        e.z    = (exp == 32'h0);
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Independent behavioural reference for the random run.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'b000: if (f7) return a - b; else return a + b;
            3'b001: return a << b[4:0];
            3'b010: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: return (a < b) ? 32'd1 : 32'd0;
            3'b100: return a ^ b;
            3'b101: begin
                if (f7) return sa >>> b[4:0];
                return a >> b[4:0];
            end
            3'b110: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Monitor: one result per rising edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, rd, e.rd);
                check({e.name, "_z"}, {31'h0, z}, {31'h0, e.z});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;

        rst_n  = 1'b0;
        rs1    = 32'd1;
        rs2    = 32'd1;
        funct3 = 3'b000;
        funct7 = 1'b0;

        // Reset held across edges, then released between edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd", rd, 32'h0);
        check("reset_z", {31'h0, z}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_rd", rd, 32'h0);
        check("release_z", {31'h0, z}, 32'h0);

        // Directed vectors, back-to-back on consecutive edges.
        issue("add_20_30",    3'b000, 1'b0, 32'd20,        32'd30,   32'd50);
        issue("sub_8_3",      3'b000, 1'b1, 32'd8,         32'd3,    32'd5);
        issue("sub_20_20",    3'b000, 1'b1, 32'd20,        32'd20,   32'd0);
        issue("sub_0_1",      3'b000, 1'b1, 32'd0,         32'd1,    32'hFFFF_FFFF);
        issue("add_wrap",     3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1,    32'd0);
        issue("sll_8_3",      3'b001, 1'b0, 32'd8,         32'd3,    32'd64);
        issue("srl_8_3",      3'b101, 1'b0, 32'd8,         32'd3,    32'd1);
        issue("sra_msb_4",    3'b101, 1'b1, 32'h8000_0000, 32'd4,    32'hF800_0000);
        issue("srl_msb_4",    3'b101, 1'b0, 32'h8000_0000, 32'd4,    32'h0800_0000);
        issue("sll_rs2_23",   3'b001, 1'b0, 32'd8,         32'h23,   32'd64);
        issue("sra_rs2_23",   3'b101, 1'b1, 32'h8000_0000, 32'h23,   32'hF000_0000);
        issue("srl_by_0",     3'b101, 1'b0, 32'hDEAD_BEEF, 32'd0,    32'hDEAD_BEEF);
        issue("sll_by_20h",   3'b001, 1'b0, 32'hDEAD_BEEF, 32'h20,   32'hDEAD_BEEF);
        issue("sra_by_0",     3'b101, 1'b1, 32'h8000_0001, 32'd0,    32'h8000_0001);
        issue("sll_f7",       3'b001, 1'b1, 32'd8,         32'd3,    32'd64);
        issue("slt_8_3",      3'b010, 1'b0, 32'd8,         32'd3,    32'd0);
        issue("slt_m1_1",     3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,    32'd1);
        issue("sltu_max_1",   3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1,    32'd0);
        issue("sltu_3_8",     3'b011, 1'b0, 32'd3,         32'd8,    32'd1);
        issue("slt_f7",       3'b010, 1'b1, 32'hFFFF_FFFF, 32'd1,    32'd1);
        issue("xor_20_30",    3'b100, 1'b0, 32'd20,        32'd30,   32'd10);
        issue("or_20_30",     3'b110, 1'b0, 32'd20,        32'd30,   32'd30);
        issue("and_20_30",    3'b111, 1'b0, 32'd20,        32'd30,   32'd20);
        issue("xor_f7",       3'b100, 1'b1, 32'd20,        32'd30,   32'd10);
        issue("or_f7",        3'b110, 1'b1, 32'd20,        32'd30,   32'd30);
        issue("and_f7",       3'b111, 1'b1, 32'd20,        32'd30,   32'd20);
        drain();

        // Short reset pulse between edges: outputs clear immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("pulse_rd", rd, 32'h0);
        check("pulse_z", {31'h0, z}, 32'h0);
        #1;
        rst_n = 1'b1;
        drain();

        // Reset held across an edge discards the op presented at that edge.
        @(negedge clk);
        rs1    = 32'd5;
        rs2    = 32'd6;
        funct3 = 3'b000;
        funct7 = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check("inflight_rd", rd, 32'h0);
        check("inflight_z", {31'h0, z}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst_sub", 3'b000, 1'b1, 32'd9, 32'd4, 32'd5);
        issue("post_rst_or",  3'b110, 1'b0, 32'h0, 32'h0, 32'd0);
        drain();

        // Random operands against the reference model.
        for (int i = 0; i < 10000; i++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 32'h0;
                2: b = {27'h0, 5'($urandom)};
                default: ;
            endcase
            issue("random", f3, f7, a, b, ref_alu(f3, f7, a, b));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
